// File: rtl/sram_controller_pkg.sv
// Shared types and helpers for the asynchronous SRAM controller.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_WRITE_HOLD
  } state_e;

  // Registered pin strobes plus the data-bus drive enable.
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic drive;
  } strobe_t;

  localparam strobe_t STROBE_IDLE  = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, drive: 1'b0};
  localparam strobe_t STROBE_READ  = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, drive: 1'b0};
  localparam strobe_t STROBE_WRITE = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, drive: 1'b1};
  localparam strobe_t STROBE_HOLD  = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, drive: 1'b1};

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Fabric-side request/response bundle of the SRAM controller.
interface sram_controller_if #(
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned DATA_BITS = 8
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_data;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_data_valid;

  modport master (
    output req_valid, req_write, req_addr, req_data,
    input  req_ready, rd_data, rd_data_valid
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data,
    output req_ready, rd_data, rd_data_valid
  );

endinterface

// File: rtl/sram_controller_io.sv
// SRAM pad ring: registered address/strobes/write data and the tristate data pad.
module sram_controller_io
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  input  strobe_t              strobe,
  output logic [DATA_BITS-1:0] rdata_c,
  output logic [ADDR_BITS-1:0] sram_addr,
  inout  wire  [DATA_BITS-1:0] sram_data,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  strobe_t              strobe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= STROBE_IDLE;
    end else begin
      strobe_q <= strobe;
      if (load) begin
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  assign sram_data = strobe_q.drive ? wdata_q : {DATA_BITS{1'bz}};
  assign rdata_c   = sram_data;
  assign sram_addr = addr_q;
  assign sram_ce_n = strobe_q.ce_n;
  assign sram_oe_n = strobe_q.oe_n;
  assign sram_we_n = strobe_q.we_n;

endmodule

// File: rtl/sram_controller.sv
// Single-word read/write initiator for an asynchronous CE#/OE#/WE# SRAM.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 9,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned WRITE_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  sram_controller_if.slave     bus,
  output logic [ADDR_BITS-1:0] sram_addr_o,
  inout  wire  [DATA_BITS-1:0] sram_data_io,
  output logic                 sram_ce_n_o,
  output logic                 sram_oe_n_o,
  output logic                 sram_we_n_o
);

  localparam int unsigned CNT_BITS = $clog2(max2(READ_CYCLES, WRITE_CYCLES) + 1);

  state_e               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  strobe_t              strobe_d;
  logic                 load;
  logic                 capture;
  logic [DATA_BITS-1:0] rdata_c;
  logic [DATA_BITS-1:0] rd_data_q;
  logic                 rd_valid_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= capture;
      if (capture) rd_data_q <= rdata_c;
    end
  end

  // Next state and next registered pin values; pins change only on clock edges.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = STROBE_IDLE;
    load     = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          load = 1'b1;
          if (bus.req_write) begin
            state_d  = ST_WRITE;
            cnt_d    = CNT_BITS'(WRITE_CYCLES);
            strobe_d = STROBE_WRITE;
          end else begin
            state_d  = ST_READ;
            cnt_d    = CNT_BITS'(READ_CYCLES);
            strobe_d = STROBE_READ;
          end
        end
      end
      ST_READ: begin
        if (cnt_q == CNT_BITS'(1)) begin
          state_d = ST_IDLE;
          capture = 1'b1;
        end else begin
          cnt_d    = cnt_q - CNT_BITS'(1);
          strobe_d = STROBE_READ;
        end
      end
      ST_WRITE: begin
        if (cnt_q == CNT_BITS'(1)) begin
          state_d  = ST_WRITE_HOLD;
          strobe_d = STROBE_HOLD;
        end else begin
          cnt_d    = cnt_q - CNT_BITS'(1);
          strobe_d = STROBE_WRITE;
        end
      end
      ST_WRITE_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready     = (state_q == ST_IDLE) && !reset_i;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_valid_q;

  sram_controller_io #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_io (
    .clk       (clk_i),
    .reset     (reset_i),
    .load      (load),
    .addr      (bus.req_addr),
    .wdata     (bus.req_data),
    .strobe    (strobe_d),
    .rdata_c   (rdata_c),
    .sram_addr (sram_addr_o),
    .sram_data (sram_data_io),
    .sram_ce_n (sram_ce_n_o),
    .sram_oe_n (sram_oe_n_o),
    .sram_we_n (sram_we_n_o)
  );

endmodule
